// File: rtl/booth_mul_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : booth_mul_scheduler
// Description : Round-robin front end that shares one iterative Booth
//               multiplier datapath between NREQ requesters. A request is
//               accepted in IDLE, launched with a one-cycle start pulse and
//               awaited in WAIT. The product is then held in RESP until the
//               consumer takes it.
//               Optional watchdog: define BOOTH_SCHED_WDT_EN to bound the WAIT
//               phase to TIMEOUT cycles. It adds the sticky wdt_err output.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mul_scheduler #(
  parameter int N       = 16,
  parameter int M       = 16,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*N-1:0]         req_a,
  input  logic [NREQ*M-1:0]         req_b,
  output logic                      mul_start,
  output logic [N-1:0]              mul_multiplicand,
  output logic [M-1:0]              mul_multiplier,
  input  logic                      mul_done,
  input  logic [N+M-1:0]            mul_product,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [N+M-1:0]            rsp_product,
  output logic                      busy
`ifdef BOOTH_SCHED_WDT_EN
  ,
  output logic                      wdt_err
`endif
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;

  // Arbitration result for the current cycle.
  logic [IDW-1:0]   grant_idx;
  logic             grant_any;
  logic             accept;

  // Round-robin pointer and the owner of the operation in flight.
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   owner;

  // High only in the first WAIT cycle; a done seen there belongs to the
  // previous operation and must not complete this one.
  logic             wait_first;

  // Qualified completion of the current operation.
  logic             done_take;

`ifdef BOOTH_SCHED_WDT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0]    wdt_cnt;
  logic             wdt_fire;
`endif

  // --------------------------------------------------------------------------
  // Arbiter
  // --------------------------------------------------------------------------

  // Pick the first valid requester strictly after last_grant. The scan runs
  // from farthest to nearest so the nearest valid index is written last.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[(int'(last_grant) + k) % NREQ]) begin
        grant_idx = IDW'((int'(last_grant) + k) % NREQ);
        grant_any = 1'b1;
      end
    end
  end

  assign accept = (state == S_IDLE) && grant_any;

  // One-hot ready to the selected requester, only while IDLE.
  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and qualified completion.
  always_comb begin
    state_nxt = state;
    done_take = 1'b0;
`ifdef BOOTH_SCHED_WDT_EN
    wdt_fire  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (grant_any) begin
          state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mul_done && !wait_first) begin
          state_nxt = S_RESP;
          done_take = 1'b1;
        end
`ifdef BOOTH_SCHED_WDT_EN
        else if (wdt_cnt == CW'(TIMEOUT - 1)) begin
          state_nxt = S_RESP;
          wdt_fire  = 1'b1;
        end
`endif
      end
      S_RESP: begin
        // The grant for the next operation waits until the following
        // IDLE cycle, so a response hand-off never overlaps a new grant.
        if (rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign mul_start = (state == S_LAUNCH);
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);

  // --------------------------------------------------------------------------
  // Operand and response registers
  // --------------------------------------------------------------------------

  // Latch operands and owner on acceptance, and capture the product on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
      owner            <= '0;
      last_grant       <= IDW'(NREQ - 1);
      wait_first       <= 1'b0;
      rsp_product      <= '0;
      rsp_id           <= '0;
    end else begin
      if (accept) begin
        // Operands go to the datapath untouched; it owns sign handling.
        mul_multiplicand <= req_a[int'(grant_idx)*N +: N];
        mul_multiplier   <= req_b[int'(grant_idx)*M +: M];
        owner            <= grant_idx;
        last_grant       <= grant_idx;
      end

      wait_first <= (state == S_LAUNCH);

      if (done_take) begin
        rsp_product <= mul_product;
        rsp_id      <= owner;
      end
`ifdef BOOTH_SCHED_WDT_EN
      else if (wdt_fire) begin
        rsp_product <= '1;
        rsp_id      <= owner;
      end
`endif
    end
  end

`ifdef BOOTH_SCHED_WDT_EN
  // --------------------------------------------------------------------------
  // Watchdog
  // --------------------------------------------------------------------------

  // Count WAIT cycles from zero on every entry; the error flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_cnt <= '0;
      wdt_err <= 1'b0;
    end else begin
      if (state == S_WAIT) begin
        wdt_cnt <= wdt_cnt + 1'b1;
      end else begin
        wdt_cnt <= '0;
      end
      if (wdt_fire) begin
        wdt_err <= 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_booth_mul_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_mul_scheduler
// Description : Directed bench for booth_mul_scheduler. It contains a
//               behavioural datapath, a transaction-level reference model
//               and literal spot checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_mul_scheduler;

  localparam int N       = 16;
  localparam int M       = 16;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;
  localparam int IDW     = 2;
  localparam int P       = N + M;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*M-1:0] req_b;
  logic              mul_start;
  logic [N-1:0]      mul_multiplicand;
  logic [M-1:0]      mul_multiplier;
  logic              mul_done;
  logic [P-1:0]      mul_product;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [P-1:0]      rsp_product;
  logic              busy;
`ifdef BOOTH_SCHED_WDT_EN
  logic              wdt_err;
`endif

  always #5 clk = ~clk;

  booth_mul_scheduler #(.N(N), .M(M), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_a            (req_a),
    .req_b            (req_b),
    .mul_start        (mul_start),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_done         (mul_done),
    .mul_product      (mul_product),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_id           (rsp_id),
    .rsp_product      (rsp_product),
    .busy             (busy)
`ifdef BOOTH_SCHED_WDT_EN
    ,
    .wdt_err          (wdt_err)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural Booth datapath: product appears dp_lat edges after it sees
  // the start pulse. In stale_mode, done stays high once set, as a datapath
  // would if done were a level that is never cleared.
  // --------------------------------------------------------------------------
  int dp_lat     = 16;
  bit stale_mode = 1'b0;
  bit dp_dead    = 1'b0;

  initial begin : datapath
    logic                s_start;
    logic                s_rst;
    logic [N-1:0]        s_a;
    logic [M-1:0]        s_b;
    int                  cnt;
    bit                  active;
    logic signed [P-1:0] pend;
    mul_done    = 1'b0;
    mul_product = '0;
    cnt         = 0;
    active      = 1'b0;
    pend        = '0;
    forever begin
      @(negedge clk);
      s_start = mul_start;
      s_rst   = rst;
      s_a     = mul_multiplicand;
      s_b     = mul_multiplier;
      @(posedge clk);
      #1;
      if (s_rst) begin
        active   = 1'b0;
        mul_done = 1'b0;
      end else if (s_start && !dp_dead) begin
        active = 1'b1;
        cnt    = dp_lat;
        pend   = $signed(s_a) * $signed(s_b);
        if (!stale_mode) mul_done = 1'b0;
      end else if (active) begin
        cnt--;
        if (cnt <= 0) begin
          active      = 1'b0;
          mul_done    = 1'b1;
          mul_product = pend;
        end
      end else if (!stale_mode) begin
        mul_done = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Reference model and the per-cycle compare process
  // --------------------------------------------------------------------------
  // Phases: 0 idle, 1 launch, 2 wait, 3 response.
  int                  m_phase;
  int                  m_last;
  bit                  m_wfirst;
  int                  m_wcnt;
  logic [N-1:0]        m_a;
  logic [M-1:0]        m_b;
  int                  m_id;
  logic signed [P-1:0] m_prod;
  int                  m_rid;
  logic [P-1:0]        m_rprod;
  bit                  m_werr;
  bit                  m_known = 1'b0;
  int                  glog[$];
  int                  start_cnt = 0;

  initial begin : compare
    logic [NREQ-1:0] exp_ready;
    bit              any;
    int              pick;
    forever begin
      @(negedge clk);
      exp_ready = '0;
      any       = 1'b0;
      pick      = 0;
      if (m_phase == 0) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (!any && req_valid[(m_last + k) % NREQ]) begin
            any  = 1'b1;
            pick = (m_last + k) % NREQ;
          end
        end
      end
      if (any) exp_ready[pick] = 1'b1;

      if (m_known) begin
        chk("req_ready",        64'(req_ready),        64'(exp_ready));
        chk("mul_start",        64'(mul_start),        64'(m_phase == 1));
        chk("busy",             64'(busy),             64'(m_phase != 0));
        chk("rsp_valid",        64'(rsp_valid),        64'(m_phase == 3));
        chk("mul_multiplicand", 64'(mul_multiplicand), 64'(m_a));
        chk("mul_multiplier",   64'(mul_multiplier),   64'(m_b));
        chk("rsp_id",           64'(rsp_id),           64'(m_rid));
        chk("rsp_product",      64'(rsp_product),      64'(m_rprod));
`ifdef BOOTH_SCHED_WDT_EN
        chk("wdt_err",          64'(wdt_err),          64'(m_werr));
`endif
      end

      if (!rst) begin
        for (int j = 0; j < NREQ; j++) begin
          if (req_ready[j] && req_valid[j]) glog.push_back(j);
        end
        if (mul_start) start_cnt++;
      end

      // Advance the model by one clock.
      if (rst) begin
        m_phase  = 0;
        m_last   = NREQ - 1;
        m_wfirst = 1'b0;
        m_wcnt   = 0;
        m_a      = '0;
        m_b      = '0;
        m_id     = 0;
        m_prod   = '0;
        m_rid    = 0;
        m_rprod  = '0;
        m_werr   = 1'b0;
        m_known  = 1'b1;
      end else begin
        case (m_phase)
          0: if (any) begin
            m_a     = req_a[pick*N +: N];
            m_b     = req_b[pick*M +: M];
            m_prod  = $signed(m_a) * $signed(m_b);
            m_id    = pick;
            m_last  = pick;
            m_phase = 1;
          end
          1: begin
            m_phase  = 2;
            m_wfirst = 1'b1;
            m_wcnt   = 0;
          end
          2: begin
            if (mul_done && !m_wfirst) begin
              m_rid   = m_id;
              m_rprod = m_prod;
              m_phase = 3;
            end
`ifdef BOOTH_SCHED_WDT_EN
            else if (m_wcnt + 1 == TIMEOUT) begin
              m_rid   = m_id;
              m_rprod = '1;
              m_werr  = 1'b1;
              m_phase = 3;
            end
`endif
            m_wfirst = 1'b0;
            m_wcnt++;
          end
          default: if (rsp_ready) m_phase = 0;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input int limit);
    int c = 0;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && c < limit) begin
      @(negedge clk);
      c++;
    end
    chk(name, 64'(rsp_valid), 64'd1);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int c = 0;
    @(negedge clk);
    while (busy !== 1'b0 && c < limit) begin
      @(negedge clk);
      c++;
    end
    chk(name, 64'(busy), 64'd0);
  endtask

  task automatic wait_grants(input string name, input int n, input int limit);
    int c = 0;
    @(negedge clk);
    while (glog.size() < n && c < limit) begin
      @(negedge clk);
      c++;
    end
    chk(name, 64'(glog.size()), 64'(n));
  endtask

  task automatic set_lane(input int i, input logic [N-1:0] a, input logic [M-1:0] b);
    req_a[i*N +: N] = a;
    req_b[i*M +: M] = b;
  endtask

  // --------------------------------------------------------------------------
  // Directed scenarios
  // --------------------------------------------------------------------------
  initial begin : stimulus
    int exp_g[5];
    exp_g = '{0, 1, 2, 3, 0};

    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (3) tick();

    // Reset values
    @(negedge clk);
    chk("rst_req_ready",    64'(req_ready),        64'd0);
    chk("rst_busy",         64'(busy),             64'd0);
    chk("rst_mul_start",    64'(mul_start),        64'd0);
    chk("rst_rsp_valid",    64'(rsp_valid),        64'd0);
    chk("rst_multiplicand", 64'(mul_multiplicand), 64'd0);
    chk("rst_multiplier",   64'(mul_multiplier),   64'd0);
    chk("rst_rsp_product",  64'(rsp_product),      64'd0);
    chk("rst_rsp_id",       64'(rsp_id),           64'd0);
    tick();
    rst = 1'b0;

    // Single operation, 3 * -5 through a 16-cycle datapath
    start_cnt = 0;
    dp_lat    = 16;
    set_lane(0, 16'd3, 16'hFFFB);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    wait_rsp("t1_rsp_timeout", 60);
    chk("t1_rsp_id",       64'(rsp_id),      64'd0);
    chk("t1_rsp_product",  64'(rsp_product), 64'h0000_0000_FFFF_FFF1);
    chk("t1_start_pulses", 64'(start_cnt),   64'd1);
    tick();
    wait_idle("t1_idle_timeout", 20);

    // All four requesters valid: rotation 0,1,2,3,0
    tick();
    do_reset();
    glog.delete();
    set_lane(0, 16'd11,    16'hFFFD);
    set_lane(1, 16'hFF00,  16'd4);
    set_lane(2, 16'd300,   16'h7FFF);
    set_lane(3, 16'd5,     16'h8000);
    dp_lat    = 2;
    req_valid = 4'b1111;
    wait_grants("t2_grant_timeout", 5, 200);
    tick();
    req_valid = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t2_grant_%0d", i), 64'(glog[i]), 64'(exp_g[i]));
    end
    wait_idle("t2_idle_timeout", 40);

    // Response held for several cycles with rsp_ready low
    tick();
    glog.delete();
    set_lane(1, 16'd100, 16'hFFFD);
    rsp_ready = 1'b0;
    req_valid = 4'b0110;
    wait_rsp("t3_rsp_timeout", 40);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid",   64'(rsp_valid),   64'd1);
      chk("t3_hold_id",      64'(rsp_id),      64'd1);
      chk("t3_hold_product", 64'(rsp_product), 64'h0000_0000_FFFF_FED4);
      chk("t3_hold_noready", 64'(req_ready),   64'd0);
      @(negedge clk);
    end
    tick();
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    wait_grants("t3_grant_timeout", 2, 20);
    tick();
    req_valid = 4'b0000;
    chk("t3_grant_0", 64'(glog[0]), 64'd1);
    chk("t3_grant_1", 64'(glog[1]), 64'd2);
    wait_idle("t3_idle_timeout", 40);

    // mul_done stuck high from the previous operation
    tick();
    stale_mode = 1'b1;
    dp_lat     = 1;
    set_lane(3, 16'd7, 16'd9);
    req_valid  = 4'b1000;
    tick();
    req_valid  = 4'b0000;
    wait_rsp("t4a_rsp_timeout", 20);
    chk("t4a_rsp_product", 64'(rsp_product), 64'h0000_0000_0000_003F);
    tick();
    wait_idle("t4a_idle_timeout", 20);
    tick();
    set_lane(0, 16'hFFFE, 16'd100);
    req_valid  = 4'b0001;
    tick();
    req_valid  = 4'b0000;
    wait_rsp("t4b_rsp_timeout", 20);
    chk("t4b_rsp_id",      64'(rsp_id),      64'd0);
    chk("t4b_rsp_product", 64'(rsp_product), 64'h0000_0000_FFFF_FF38);
    tick();
    wait_idle("t4b_idle_timeout", 20);
    stale_mode = 1'b0;

    // Reset while the operation is in WAIT
    tick();
    dp_lat = 20;
    set_lane(2, 16'd5, 16'd5);
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_busy",         64'(busy),             64'd0);
    chk("t5_rsp_valid",    64'(rsp_valid),        64'd0);
    chk("t5_mul_start",    64'(mul_start),        64'd0);
    chk("t5_multiplicand", 64'(mul_multiplicand), 64'd0);
    chk("t5_rsp_product",  64'(rsp_product),      64'd0);
    chk("t5_rsp_id",       64'(rsp_id),           64'd0);
    tick();
    glog.delete();
    dp_lat    = 3;
    req_valid = 4'b1111;
    tick();
    req_valid = 4'b0000;
    wait_grants("t5_grant_timeout", 1, 5);
    chk("t5_first_grant", 64'(glog[0]), 64'd0);
    wait_rsp("t5_rsp_timeout", 30);
    tick();
    wait_idle("t5_idle_timeout", 20);

`ifdef BOOTH_SCHED_WDT_EN
    // Datapath never completes: the watchdog forces a response
    tick();
    do_reset();
    dp_dead   = 1'b1;
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    wait_rsp("t6_rsp_timeout", 200);
    chk("t6_rsp_product", 64'(rsp_product), 64'h0000_0000_FFFF_FFFF);
    chk("t6_wdt_err",     64'(wdt_err),     64'd1);
    repeat (4) tick();
    @(negedge clk);
    chk("t6_wdt_sticky",  64'(wdt_err),     64'd1);
    tick();
    do_reset();
    @(negedge clk);
    chk("t6_wdt_cleared", 64'(wdt_err),     64'd0);
    dp_dead = 1'b0;
`endif

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : global_timeout
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
